// File: rtl/cmavg_pkg.sv
// Shared sizing helpers and the shift-round-saturate function for cmoving_avg_multi.
//   acc_width : accumulator width (sample width + window exponent + sign headroom)
//   ptr_width : history RAM address width
//   len_width : width of the window-exponent input
//   round_sat : (acc + 2^(sh-1)) >>> sh, then clamp to a dw-bit signed range
package cmavg_pkg;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned max_log2);
    return dw + max_log2 + 1;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned max_log2);
    return (max_log2 == 0) ? 1 : max_log2;
  endfunction

  function automatic int unsigned len_width(input int unsigned max_log2);
    return (max_log2 == 0) ? 1 : $clog2(max_log2 + 1);
  endfunction

  // Round half up, then clip; sh == 0 is a straight passthrough.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int unsigned       sh,
                                                   input int unsigned       dw);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc;
    if (sh != 0) r = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/cmavg_hist_ram.sv
// Sample history store: simple dual-port RAM, registered read.
// A read and write to the same address in one cycle returns the old contents.
//   clk_i            clock
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i/rdata_o  read port (rdata_o holds when re_i is low)
module cmavg_hist_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Non-blocking read of mem_q gives read-before-write on collision.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cmoving_avg_multi.sv
// NUM_CH-lane boxcar moving average over a window of 2^log2_len samples, AXI-Stream in/out.
//   clk, reset (async, active high), clear (sync flush)
//   log2_len         window exponent, captured on reset/clear only, clamped to MAX_LOG2_LEN
//   in_tdata/in_tvalid/in_tlast/in_tready     input stream, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_tdata/out_tvalid/out_tlast/out_tready per-lane rounded averages, same packing
module cmoving_avg_multi
  import cmavg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned MAX_LOG2_LEN = 11,
  parameter int unsigned FILL_MODE    = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic [len_width(MAX_LOG2_LEN)-1:0]    log2_len,
  input  logic [NUM_CH*DATA_WIDTH-1:0]          in_tdata,
  input  logic                                  in_tvalid,
  input  logic                                  in_tlast,
  output logic                                  in_tready,
  output logic [NUM_CH*DATA_WIDTH-1:0]          out_tdata,
  output logic                                  out_tvalid,
  output logic                                  out_tlast,
  input  logic                                  out_tready
);

  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned BUS_W  = NUM_CH * DATA_WIDTH;
  localparam int unsigned ACC_W  = acc_width(DATA_WIDTH, MAX_LOG2_LEN);
  localparam int unsigned PTR_W  = ptr_width(MAX_LOG2_LEN);
  localparam int unsigned LEN_W  = len_width(MAX_LOG2_LEN);
  localparam int unsigned FILL_W = MAX_LOG2_LEN + 1;

  logic                    load_q, load_d;
  logic [LEN_W-1:0]        len_q, len_d, len_in_c, len_eff_c;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [FILL_W-1:0]       fill_q, fill_d, win_c, win_m1_c;
  logic                    s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic                    s1_zero_q, s1_zero_d, s1_full_q, s1_full_d;
  logic [BUS_W-1:0]        s1_data_q, s1_data_d;
  logic signed [ACC_W-1:0] acc_q [NUM_CH];
  logic signed [ACC_W-1:0] acc_d [NUM_CH];
  logic signed [ACC_W-1:0] acc_sum_c [NUM_CH];
  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [BUS_W-1:0]        out_data_q, out_data_d, avg_c, rd_data;
  logic                    en_c, accept_c;

  assign en_c      = !out_valid_q || out_tready;
  assign in_tready = en_c && !clear && !reset;
  assign accept_c  = in_tvalid && in_tready;

  // load_q marks the first cycle after reset: the window comes straight from the port
  // until len_q has captured it, so len_q itself needs only a constant reset value.
  assign len_in_c  = (32'(log2_len) > MAX_LOG2_LEN) ? LEN_W'(MAX_LOG2_LEN) : log2_len;
  assign len_eff_c = load_q ? len_in_c : len_q;
  assign win_c     = FILL_W'(1) << len_eff_c;
  assign win_m1_c  = win_c - FILL_W'(1);

  cmavg_hist_ram #(
    .DATA_W (BUS_W),
    .ADDR_W (PTR_W)
  ) u_hist (
    .clk_i   (clk),
    .we_i    (accept_c),
    .waddr_i (ptr_q),
    .wdata_i (in_tdata),
    .re_i    (accept_c),
    .raddr_i (ptr_q),
    .rdata_o (rd_data)
  );

  // Per-lane running sum and rounded average of the stage-1 beat.
  always_comb begin
    logic [DW-1:0]      xo;
    logic signed [63:0] rs;
    avg_c = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      xo           = s1_zero_q ? '0 : rd_data[k*DW +: DW];
      acc_sum_c[k] = acc_q[k] + ACC_W'($signed(s1_data_q[k*DW +: DW])) - ACC_W'($signed(xo));
      rs           = round_sat(64'(acc_sum_c[k]), 32'(len_q), DATA_WIDTH);
      avg_c[k*DW +: DW] = rs[DW-1:0];
    end
  end

  // Next-state: clear beats everything, otherwise the whole pipe moves only on en_c.
  always_comb begin
    load_d      = 1'b0;
    len_d       = len_eff_c;
    ptr_d       = ptr_q;
    fill_d      = fill_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_zero_d   = s1_zero_q;
    s1_full_d   = s1_full_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    for (int k = 0; k < int'(NUM_CH); k++) acc_d[k] = acc_q[k];

    if (clear) begin
      len_d       = len_in_c;
      ptr_d       = '0;
      fill_d      = '0;
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_data_d  = '0;
      for (int k = 0; k < int'(NUM_CH); k++) acc_d[k] = '0;
    end else if (en_c) begin
      s1_valid_d = accept_c;
      if (accept_c) begin
        s1_data_d = in_tdata;
        s1_last_d = in_tlast;
        // Old sample is only meaningful once the window has wrapped at least once.
        s1_zero_d = fill_q < win_c;
        s1_full_d = fill_q >= win_m1_c;
        ptr_d     = (FILL_W'(ptr_q) == win_m1_c) ? '0 : ptr_q + PTR_W'(1);
        if (fill_q < win_c) fill_d = fill_q + FILL_W'(1);
      end
      out_valid_d = s1_valid_q && ((FILL_MODE == 0) || s1_full_q);
      if (s1_valid_q) begin
        for (int k = 0; k < int'(NUM_CH); k++) acc_d[k] = acc_sum_c[k];
        out_data_d = avg_c;
        out_last_d = s1_last_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q      <= 1'b1;
      len_q       <= '0;
      ptr_q       <= '0;
      fill_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_full_q   <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      for (int k = 0; k < int'(NUM_CH); k++) acc_q[k] <= '0;
    end else begin
      load_q      <= load_d;
      len_q       <= len_d;
      ptr_q       <= ptr_d;
      fill_q      <= fill_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_zero_q   <= s1_zero_d;
      s1_full_q   <= s1_full_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      for (int k = 0; k < int'(NUM_CH); k++) acc_q[k] <= acc_d[k];
    end
  end

  assign out_tdata  = out_data_q;
  assign out_tvalid = out_valid_q;
  assign out_tlast  = out_last_q;

endmodule
